aio_eep_rd_arbiter: RTL and testbench

Round-robin arbiter that shares the single EEPROM read port among NREQ requesters (constant-table loader, channel-RAM loader, runtime readers) in the AIO init path. It grants one requester at a time and latches that requester's address and length. It issues one read command to the EEPROM reader and routes the returned byte stream only to the owner. It flags timeouts and length mismatches, so requesters no longer share the port through an OR of their outputs.

---
 rtl/aio_eep_rd_arbiter_if.sv | 32 +++
 rtl/aio_eep_rd_arbiter.sv | 135 +++++++++++++
 tb/tb_aio_eep_rd_arbiter.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/aio_eep_rd_arbiter_if.sv
// rtl/aio_eep_rd_arbiter_if.sv - requester and EEPROM-reader signal bundle for the read-port arbiter
interface aio_eep_rd_arbiter_if #(
  parameter int NREQ = 3
);
  logic [NREQ-1:0]    req_rden;
  logic [NREQ*17-1:0] req_length;
  logic [NREQ*16-1:0] req_addr;
  logic [NREQ-1:0]    req_grant;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_last;
  logic [7:0]         req_data;
  logic [NREQ-1:0]    req_error;
  logic               eep_rden;
  logic [16:0]        eep_length;
  logic [15:0]        eep_addr;
  logic               eep_valid;
  logic               eep_last;
  logic [7:0]         eep_data;
  logic               arb_busy;

  modport slave (
    input  req_rden, req_length, req_addr, eep_valid, eep_last, eep_data,
    output req_grant, req_valid, req_last, req_data, req_error,
           eep_rden, eep_length, eep_addr, arb_busy
  );

  modport master (
    output req_rden, req_length, req_addr, eep_valid, eep_last, eep_data,
    input  req_grant, req_valid, req_last, req_data, req_error,
           eep_rden, eep_length, eep_addr, arb_busy
  );
endinterface

// File: rtl/aio_eep_rd_arbiter.sv
// rtl/aio_eep_rd_arbiter.sv - round-robin owner of the single EEPROM read port
module aio_eep_rd_arbiter #(
  parameter int NREQ        = 3,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic               sys_clk,
  input  logic               glbl_rst_n,
  aio_eep_rd_arbiter_if.slave bus
);
  localparam int OW = $clog2(NREQ);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [OW:0]    NREQ_W   = (OW+1)'(NREQ);
  localparam logic [TW-1:0]  TMR_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [16:0]    LEN_MAX  = 17'h10000;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_GRANT = 3'd1;
  localparam logic [2:0] S_CMD   = 3'd2;
  localparam logic [2:0] S_XFER  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]      r_state;
  logic [OW-1:0]   r_owner;
  logic [OW-1:0]   r_last_owner;
  logic [15:0]     r_addr;
  logic [16:0]     r_len;
  logic [16:0]     r_cnt;
  logic [TW-1:0]   r_tmr;
  logic [NREQ-1:0] r_error;

  logic            w_found;
  logic [OW-1:0]   w_winner;
  logic [OW:0]     w_idx;
  logic [16:0]     w_win_len;
  logic [15:0]     w_win_addr;
  logic            w_len_bad;
  logic [NREQ-1:0] w_win_oh;
  logic [NREQ-1:0] w_owner_oh;
  logic            w_active;
  logic            w_xfer_byte;

  // Search starts one past the previous owner, so every waiter is reached within NREQ-1 transfers.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = {1'b0, r_last_owner} + (OW+1)'(k);
      if (w_idx >= NREQ_W) w_idx = w_idx - NREQ_W;
      if (!w_found && bus.req_rden[w_idx[OW-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_idx[OW-1:0];
      end
    end
  end

  assign w_win_len  = bus.req_length[17*int'(w_winner) +: 17];
  assign w_win_addr = bus.req_addr[16*int'(w_winner) +: 16];
  assign w_len_bad  = (w_win_len == 17'd0) || (w_win_len > LEN_MAX);
  assign w_win_oh   = NREQ'(1) << w_winner;
  assign w_owner_oh = NREQ'(1) << r_owner;

  always_ff @(posedge sys_clk or negedge glbl_rst_n) begin
    if (!glbl_rst_n) begin
      r_state      <= S_IDLE;
      r_owner      <= '0;
      r_last_owner <= OW'(NREQ - 1);
      r_addr       <= '0;
      r_len        <= '0;
      r_cnt        <= '0;
      r_tmr        <= '0;
      r_error      <= '0;
    end else begin
      r_error <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_owner <= w_winner;
            if (w_len_bad) begin
              r_error <= w_win_oh;
              r_state <= S_DONE;
            end else begin
              r_addr  <= w_win_addr;
              r_len   <= w_win_len;
              r_state <= S_GRANT;
            end
          end
        end
        S_GRANT: r_state <= S_CMD;
        S_CMD: begin
          // The command cycle itself counts toward the first-byte timeout.
          r_cnt   <= '0;
          r_tmr   <= TW'(1);
          r_state <= S_XFER;
        end
        S_XFER: begin
          if (bus.eep_valid) begin
            r_cnt <= r_cnt + 17'd1;
            r_tmr <= '0;
            if (bus.eep_last) begin
              if (r_cnt + 17'd1 != r_len) r_error <= w_owner_oh;
              r_state <= S_DONE;
            end else if (r_cnt == r_len) begin
              r_error <= w_owner_oh;
              r_state <= S_DONE;
            end
          end else if (r_tmr == TMR_LAST) begin
            r_error <= w_owner_oh;
            r_state <= S_DONE;
          end else begin
            r_tmr <= r_tmr + TW'(1);
          end
        end
        S_DONE: begin
          r_last_owner <= r_owner;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_active    = (r_state == S_GRANT) || (r_state == S_CMD) || (r_state == S_XFER);
  assign w_xfer_byte = (r_state == S_XFER) && bus.eep_valid;

  assign bus.req_grant  = w_active ? w_owner_oh : '0;
  assign bus.req_valid  = w_xfer_byte ? w_owner_oh : '0;
  assign bus.req_last   = (w_xfer_byte && bus.eep_last) ? w_owner_oh : '0;
  assign bus.req_data   = w_xfer_byte ? bus.eep_data : 8'h00;
  assign bus.req_error  = r_error;
  assign bus.eep_rden   = (r_state == S_CMD);
  assign bus.eep_length = r_len;
  assign bus.eep_addr   = r_addr;
  assign bus.arb_busy   = (r_state != S_IDLE);
endmodule

// File: tb/tb_aio_eep_rd_arbiter.sv
// tb/tb_aio_eep_rd_arbiter.sv - directed vector bench for the EEPROM read-port arbiter
module tb_aio_eep_rd_arbiter;
  localparam int NREQ = 3;
  localparam int TOUT = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aio_eep_rd_arbiter_if #(.NREQ(NREQ)) bus();

  aio_eep_rd_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(TOUT)) u_dut (
    .sys_clk   (clk),
    .glbl_rst_n(rst_n),
    .bus       (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          rq;
    logic [15:0] addr;
    logic [16:0] len;
    int          nbytes;
    bit          last_on_final;
    int          err_kind;  // 0 none, 1 transfer error, 2 bad length
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    n_checks++;
    if (!$onehot0(bus.req_grant)) begin
      n_fail++;
      $display("FAIL grant_onehot: got %b", bus.req_grant);
    end
  end

  task automatic set_req(input int rq, input logic [15:0] a, input logic [16:0] l);
    bus.req_addr[16*rq +: 16]   = a;
    bus.req_length[17*rq +: 17] = l;
    bus.req_rden[rq]            = 1'b1;
  endtask

  task automatic wait_owner(output int idx, output bit ok, output int waited);
    ok = 1'b0;
    idx = -1;
    waited = 0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      waited++;
      if (bus.req_grant != '0 || bus.req_error != '0) ok = 1'b1;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_owner: no grant or error within 20 cycles");
    end else begin
      for (int i = 0; i < NREQ; i++)
        if (bus.req_grant[i] || bus.req_error[i]) idx = i;
    end
  endtask

  // Entered at the first negedge with the grant visible; leaves in IDLE with the request dropped.
  task automatic serve(input int rq, input logic [15:0] a, input logic [16:0] l,
                       input int nb, input bit lf, input bit exp_err);
    logic [NREQ-1:0] oh;
    logic [7:0]      d;
    oh = NREQ'(1) << rq;
    check("grant", 32'(bus.req_grant), 32'(oh));
    check("eep_addr", 32'(bus.eep_addr), 32'(a));
    check("eep_length", 32'(bus.eep_length), 32'(l));
    check("rden_pre", 32'(bus.eep_rden), 32'd0);
    @(negedge clk);
    check("rden_cmd", 32'(bus.eep_rden), 32'd1);
    @(negedge clk);
    check("rden_post", 32'(bus.eep_rden), 32'd0);
    for (int b = 0; b < nb; b++) begin
      d = 8'hA0 + 8'(b);
      bus.eep_valid = 1'b1;
      bus.eep_data  = d;
      bus.eep_last  = lf && (b == nb - 1);
      #1;
      check("req_valid", 32'(bus.req_valid), 32'(oh));
      check("req_data", 32'(bus.req_data), 32'(d));
      check("req_last", 32'(bus.req_last), (lf && b == nb - 1) ? 32'(oh) : 32'd0);
      @(negedge clk);
    end
    bus.eep_valid = 1'b0;
    bus.eep_last  = 1'b0;
    check("grant_done", 32'(bus.req_grant), 32'd0);
    check("req_error", 32'(bus.req_error), exp_err ? 32'(oh) : 32'd0);
    bus.req_rden[rq] = 1'b0;
    @(negedge clk);
    check("error_pulse", 32'(bus.req_error), 32'd0);
    check("busy_idle", 32'(bus.arb_busy), 32'd0);
  endtask

  initial begin
    int  idx;
    bit  ok;
    int  waited;
    int  cnt;

    bus.req_rden   = '0;
    bus.req_length = '0;
    bus.req_addr   = '0;
    bus.eep_valid  = 1'b0;
    bus.eep_last   = 1'b0;
    bus.eep_data   = 8'h00;

    vecs[0] = '{1, 16'h0100, 17'd4,       4, 1'b1, 0};
    vecs[1] = '{0, 16'h1234, 17'd1,       1, 1'b1, 0};
    vecs[2] = '{2, 16'hABCD, 17'd5,       3, 1'b1, 1};
    vecs[3] = '{2, 16'h0042, 17'd0,       0, 1'b0, 2};
    vecs[4] = '{0, 16'h0777, 17'h10001,   0, 1'b0, 2};
    vecs[5] = '{1, 16'h0200, 17'd2,       3, 1'b0, 1};
    vecs[6] = '{2, 16'hFFFF, 17'd3,       3, 1'b1, 0};

    repeat (2) @(negedge clk);
    check("rst_grant", 32'(bus.req_grant), 32'd0);
    check("rst_error", 32'(bus.req_error), 32'd0);
    check("rst_rden", 32'(bus.eep_rden), 32'd0);
    check("rst_len", 32'(bus.eep_length), 32'd0);
    check("rst_busy", 32'(bus.arb_busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      set_req(vecs[v].rq, vecs[v].addr, vecs[v].len);
      wait_owner(idx, ok, waited);
      if (ok) begin
        check("vec_owner", 32'(idx), 32'(vecs[v].rq));
        check("vec_latency", 32'(waited), 32'd1);
        if (vecs[v].err_kind == 2) begin
          check("len_err", 32'(bus.req_error), 32'(NREQ'(1) << vecs[v].rq));
          check("len_err_grant", 32'(bus.req_grant), 32'd0);
          check("len_err_rden", 32'(bus.eep_rden), 32'd0);
          check("len_err_busy", 32'(bus.arb_busy), 32'd1);
          bus.req_rden = '0;
          @(negedge clk);
          check("len_err_idle", 32'(bus.arb_busy), 32'd0);
          check("len_err_pulse", 32'(bus.req_error), 32'd0);
          check("len_err_norden", 32'(bus.eep_rden), 32'd0);
        end else begin
          serve(vecs[v].rq, vecs[v].addr, vecs[v].len, vecs[v].nbytes,
                vecs[v].last_on_final, vecs[v].err_kind == 1);
        end
      end
      bus.req_rden = '0;
      @(negedge clk);
    end

    // Simultaneous requests: two rounds must both come out 0,1,2.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NREQ; i++) set_req(i, 16'h2000 + 16'(i), 17'd2);
      for (int k = 0; k < NREQ; k++) begin
        wait_owner(idx, ok, waited);
        if (ok && idx >= 0) begin
          check("rr_order", 32'(idx), 32'(k));
          serve(idx, 16'h2000 + 16'(idx), 17'd2, 2, 1'b1, 1'b0);
        end
      end
      bus.req_rden = '0;
      @(negedge clk);
    end

    // Silent reader: error exactly TOUT cycles after eep_rden, then stray bytes go nowhere.
    set_req(1, 16'h0300, 17'd4);
    wait_owner(idx, ok, waited);
    check("to_owner", 32'(idx), 32'd1);
    @(negedge clk);
    check("to_rden", 32'(bus.eep_rden), 32'd1);
    cnt = 0;
    for (int t = 0; t < 40 && bus.req_error == '0; t++) begin
      @(negedge clk);
      cnt++;
    end
    check("to_cycles", 32'(cnt), 32'(TOUT));
    check("to_error", 32'(bus.req_error), 32'b010);
    bus.eep_valid = 1'b1;
    bus.eep_last  = 1'b1;
    bus.eep_data  = 8'h5A;
    #1;
    check("stray_valid_done", 32'(bus.req_valid), 32'd0);
    check("stray_last_done", 32'(bus.req_last), 32'd0);
    bus.req_rden = '0;
    @(negedge clk);
    check("stray_valid_idle", 32'(bus.req_valid), 32'd0);
    bus.eep_valid = 1'b0;
    bus.eep_last  = 1'b0;
    @(negedge clk);

    // Reset while byte 2 of 8 is on the bus.
    set_req(2, 16'h0500, 17'd8);
    wait_owner(idx, ok, waited);
    check("rst_mid_owner", 32'(idx), 32'd2);
    @(negedge clk);
    @(negedge clk);
    bus.eep_valid = 1'b1;
    bus.eep_data  = 8'hA0;
    @(negedge clk);
    bus.eep_data  = 8'hA1;
    #1;
    check("pre_rst_valid", 32'(bus.req_valid), 32'b100);
    rst_n = 1'b0;
    #1;
    check("mid_rst_grant", 32'(bus.req_grant), 32'd0);
    check("mid_rst_valid", 32'(bus.req_valid), 32'd0);
    check("mid_rst_last", 32'(bus.req_last), 32'd0);
    check("mid_rst_data", 32'(bus.req_data), 32'd0);
    check("mid_rst_error", 32'(bus.req_error), 32'd0);
    check("mid_rst_rden", 32'(bus.eep_rden), 32'd0);
    check("mid_rst_addr", 32'(bus.eep_addr), 32'd0);
    check("mid_rst_len", 32'(bus.eep_length), 32'd0);
    check("mid_rst_busy", 32'(bus.arb_busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.eep_valid = 1'b0;
    bus.req_rden  = '0;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) set_req(NREQ - 1 - i, 16'h0600 + 16'(i), 17'd2);
    wait_owner(idx, ok, waited);
    check("post_rst_first", 32'(idx), 32'd0);
    if (ok && idx == 0) serve(0, 16'h0602, 17'd2, 2, 1'b1, 1'b0);
    bus.req_rden = '0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
